// File: rtl/reaction_timer_if.sv
// Bus bundle for reaction_timer.
//   master : drives Enable, Stop, ClearBest; observes the results.
//   slave  : the timer itself; observes the controls and drives Count, Score,
//            Best, Running, Done, Valid, NewBest.
interface reaction_timer_if #(
    parameter int unsigned WIDTH = 11
);
    logic             Enable;
    logic             Stop;
    logic             ClearBest;
    logic [WIDTH-1:0] Count;
    logic [WIDTH-1:0] Score;
    logic [WIDTH-1:0] Best;
    logic             Running;
    logic             Done;
    logic             Valid;
    logic             NewBest;

    modport master (
        output Enable, Stop, ClearBest,
        input  Count, Score, Best, Running, Done, Valid, NewBest
    );

    modport slave (
        input  Enable, Stop, ClearBest,
        output Count, Score, Best, Running, Done, Valid, NewBest
    );
endinterface

// File: rtl/reaction_timer.sv
// Reaction-time scorer: counts prescaled ticks while a round is armed,
// captures the count on Stop, flags a timeout at LIMIT, tracks the best score.
// Ports:
//   ClockIn : clock, rising edge
//   Reset   : synchronous, active-high
//   bus     : reaction_timer_if.slave (controls in, registered results out)
module reaction_timer #(
    parameter int unsigned WIDTH    = 11,
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned LIMIT    = (2**WIDTH) - 1
) (
    input  logic                  ClockIn,
    input  logic                  Reset,
    reaction_timer_if.slave       bus
);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] LIM      = WIDTH'(LIMIT);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUNNING  = 2'd1;
    localparam logic [1:0] ST_CAPTURED = 2'd2;
    localparam logic [1:0] ST_TIMEOUT  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] score_q, score_d;
    logic [WIDTH-1:0] best_q, best_d;
    logic             running_q, done_q;
    logic             valid_q, valid_d;
    logic             newbest_q, newbest_d;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] best_base;

    // State and output registers
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            score_q   <= '0;
            best_q    <= LIM;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            newbest_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            score_q   <= score_d;
            best_q    <= best_d;
            running_q <= (state_d == ST_RUNNING);
            done_q    <= (state_d == ST_TIMEOUT);
            valid_q   <= valid_d;
            newbest_q <= newbest_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        presc_d   = '0;
        count_d   = '0;
        score_d   = score_q;
        valid_d   = 1'b0;
        newbest_d = 1'b0;
        count_inc = count_q + WIDTH'(1);
        // A coincident capture compares against the cleared value
        best_base = bus.ClearBest ? LIM : best_q;
        best_d    = best_base;

        case (state_q)
            ST_IDLE: begin
                if (bus.Enable) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (!bus.Enable) begin
                    state_d = ST_IDLE;
                end else if (bus.Stop) begin
                    // Capture discards any tick landing on the same edge
                    state_d = ST_CAPTURED;
                    score_d = count_q;
                    valid_d = 1'b1;
                    if (count_q < best_base) begin
                        best_d    = count_q;
                        newbest_d = 1'b1;
                    end
                end else if (presc_q == PRE_LAST) begin
                    count_d = count_inc;
                    if (count_inc == LIM) begin
                        state_d = ST_TIMEOUT;
                        score_d = LIM;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                    count_d = count_q;
                end
            end
            ST_CAPTURED: begin
                if (!bus.Enable) state_d = ST_IDLE;
            end
            ST_TIMEOUT: begin
                if (!bus.Enable) state_d = ST_IDLE;
                else             count_d = LIM;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.Count   = count_q;
    assign bus.Score   = score_q;
    assign bus.Best    = best_q;
    assign bus.Running = running_q;
    assign bus.Done    = done_q;
    assign bus.Valid   = valid_q;
    assign bus.NewBest = newbest_q;
endmodule

// File: doc/reaction_timer.md
# reaction_timer

Parametrised reaction-time scorer for the game datapath. The block counts prescaled time ticks while a round is armed. It captures the count when the player presses Stop, or flags a timeout when the count reaches a programmable limit. It also tracks the best (lowest) score since reset or clear, and replaces the fixed-width, all-ones-terminal score counter in the round controller.

## Interface
- WIDTH, 11: width of Count, Score and Best.
- PRESCALE, 50000: ClockIn cycles per score tick; must be at least 1.
- LIMIT, 2**WIDTH-1: timeout count; must satisfy 1 <= LIMIT <= 2**WIDTH-1.

- ClockIn  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enable  in  1  level; high arms/holds a round, low aborts and returns to idle.
- Stop  in  1  player press; sampled only in RUNNING.
- ClearBest  in  1  sets Best to LIMIT; sampled in any state.
- Count  out  WIDTH  live tick count; 0 outside RUNNING/TIMEOUT.
- Score  out  WIDTH  last captured result; holds until the next capture or timeout.
- Best  out  WIDTH  lowest captured Score.
- Running  out  1  high in RUNNING.
- Done  out  1  high in TIMEOUT.
- Valid  out  1  one-cycle pulse when Score is updated by a capture.
- NewBest  out  1  one-cycle pulse, coincident with Valid, when Best was updated.

## Operation
- States: IDLE, RUNNING, CAPTURED, TIMEOUT. All outputs are registered.
- IDLE:
  - Count = 0 and prescaler = 0.
  - Enable=1 -> RUNNING.
- RUNNING:
  - The prescaler increments every cycle.
  - At prescaler == PRESCALE-1 it wraps to 0 and Count increments (a tick).
  - Priority, highest first: Enable=0, then Stop, then the tick.
  - Enable=0 -> IDLE. Count and prescaler clear; no Valid; Score and Best are unchanged.
  - Stop=1 (with Enable=1) -> CAPTURED. Score <= current Count; any tick in the same cycle is discarded. Valid pulses.
  - A tick that makes Count == LIMIT -> TIMEOUT. Score <= LIMIT; no Valid; Best is unchanged.
- CAPTURED:
  - Count clears to 0.
  - Stays in CAPTURED while Enable=1; Enable=0 -> IDLE.
  - A new round requires Enable to go low, then high again.
- TIMEOUT:
  - Count holds LIMIT and Done=1.
  - Enable=0 -> IDLE, which clears Count and Done.
- Best update on capture:
  - If captured value < Best: Best <= captured value and NewBest pulses with Valid.
  - Equal or greater: no change.
- ClearBest:
  - Sets Best <= LIMIT in any state.
  - If it coincides with a capture, the capture comparison wins: Best <= captured value when that value < LIMIT.
- Count saturates and never wraps. Width rule: compare only against LIMIT, never against all ones.
- Stop in IDLE, CAPTURED or TIMEOUT is ignored.
- A capture at Count=0 (press before the first tick) is legal: Score=0.

## Timing
- Reset, sampled at an edge, gives:
  - state IDLE; Count=0, Score=0, Best=LIMIT;
  - Running=0, Done=0, Valid=0, NewBest=0; prescaler=0.
  - Reset overrides all other inputs, including mid-round.
- Enable sampled high in IDLE at edge E0: Running=1 after E0.
- First tick at edge E0+PRESCALE; Count=n after edge E0+n*PRESCALE.
- Done rises at edge E0+LIMIT*PRESCALE, the same edge Count reaches LIMIT; Running falls on that edge.
- Stop sampled at edge E: Score, Best, Valid and NewBest update at E. Valid and NewBest drop at E+1.
- Enable falling: state IDLE after the edge that samples Enable=0; 1-cycle latency from any state.
- The prescaler restarts from 0 on every RUNNING entry; there is no residue between rounds.

## Test plan
All scenarios use WIDTH=4, PRESCALE=4, LIMIT=10.

- Reset, then idle 20 cycles -> Count=0, Score=0, Best=10, all flags 0.
- Enable high at E0, Stop at E0+13 -> Count=3 at the press; Score=3, Valid=1 and NewBest=1 for one cycle; Best=3; state CAPTURED.
- Second round, Stop at Count=5 -> Score=5, Valid=1, NewBest=0, Best stays 3. Then ClearBest -> Best=10.
- Enable held with no Stop -> Done=1 at E0+40, Count=10 and Score=10, no Valid, Best unchanged. Enable low -> Done=0 and Count=0 next cycle.
- Stop asserted on the edge where Count would go 9->10 -> Score=9, Valid=1, no Done. Then Enable low mid-round at Count=6 in a new round -> IDLE, Count=0, Score still 9, no Valid.
- Reset asserted in RUNNING at Count=4 with Stop also high -> all outputs at reset values, Best=10, no Valid. Also Stop pulsed in IDLE -> no change.
